stego_lsb_extractor: RTL and testbench



---
 rtl/stego_lsb_extractor_pkg.sv | 16 +
 rtl/stego_lsb_extractor_if.sv | 25 ++
 rtl/stego_lsb_extractor_packer.sv | 36 +++
 rtl/stego_lsb_extractor.sv | 99 +++++++++
 tb/tb_stego_lsb_extractor.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stego_lsb_extractor_pkg.sv
// Shared constants and FSM state type for the LSB steganography extractor.
package stego_pkg;

  localparam int PIXEL_W = 8;
  localparam int CHAR_W = 8;
  localparam logic [CHAR_W-1:0] NUL_CHAR = 8'h00;
  localparam int DEFAULT_MAX_CHARS = 130;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/stego_lsb_extractor_if.sv
// Pixel input stream and character output stream of the extractor.
// Both streams: a beat transfers on a cycle where valid & ready are both high;
// the source holds valid and data stable until that cycle, ready may toggle freely.
interface stego_lsb_extractor_if;
  import stego_pkg::*;

  logic               pix_valid;
  logic [PIXEL_W-1:0] pix_data;
  logic               pix_ready;
  logic               char_valid;
  logic [CHAR_W-1:0]  char_data;
  logic               char_last;
  logic               char_ready;

  modport slave (
    input  pix_valid, pix_data, char_ready,
    output pix_ready, char_valid, char_data, char_last
  );

  modport master (
    output pix_valid, pix_data, char_ready,
    input  pix_ready, char_valid, char_data, char_last
  );

endinterface

// File: rtl/stego_lsb_extractor_packer.sv
// Packs one bit per shift into a byte; bit order chosen by MSB_FIRST.
module lsb_byte_packer #(
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [7:0] byte_out,
  output logic       byte_full
);

  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] w_shift_next;

  // byte_out includes the bit being shifted in, so it is complete on the byte_full cycle.
  assign w_shift_next = (MSB_FIRST != 0) ? {r_shift[6:0], bit_in} : {bit_in, r_shift[7:1]};
  assign byte_out     = w_shift_next;
  assign byte_full    = shift_en & (r_bit_cnt == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
    end else if (clear) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
    end else if (shift_en) begin
      r_shift   <= w_shift_next;
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/stego_lsb_extractor.sv
// Recovers a hidden ASCII message from the LSBs of a stego pixel stream,
// stopping at NUL or after MAX_CHARS characters.
module stego_lsb_extractor
  import stego_pkg::*;
#(
  parameter int MAX_CHARS = DEFAULT_MAX_CHARS,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  stego_lsb_extractor_if.slave  s_if,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      char_count,
  output state_t                o_dbg_state
);

  state_t              r_state;
  state_t              w_state_next;
  logic [CHAR_W-1:0]   r_char;
  logic [CNT_W-1:0]    r_count;
  logic                w_accept;
  logic                w_clear;
  logic                w_char_hs;
  logic                w_last;
  logic                w_byte_full;
  logic [CHAR_W-1:0]   w_byte;
  logic                w_unused_pix;

  assign w_unused_pix = ^s_if.pix_data[PIXEL_W-1:1];

  assign w_accept  = s_if.pix_valid & (r_state == COLLECT);
  assign w_clear   = start & ((r_state == IDLE) | (r_state == DONE));
  assign w_char_hs = (r_state == EMIT) & s_if.char_ready;
  assign w_last    = (r_char == NUL_CHAR) | (r_count == CNT_W'(MAX_CHARS - 1));

  lsb_byte_packer #(
    .MSB_FIRST (MSB_FIRST)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_clear),
    .shift_en  (w_accept),
    .bit_in    (s_if.pix_data[0]),
    .byte_out  (w_byte),
    .byte_full (w_byte_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_char  <= NUL_CHAR;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_byte_full) r_char <= w_byte;
      if (w_clear) r_count <= '0;
      else if (w_char_hs) r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    s_if.pix_ready  = 1'b0;
    s_if.char_valid = 1'b0;
    s_if.char_last  = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = COLLECT;
      end
      COLLECT: begin
        s_if.pix_ready = 1'b1;
        busy           = 1'b1;
        if (w_byte_full) w_state_next = EMIT;
      end
      EMIT: begin
        s_if.char_valid = 1'b1;
        // char_last is only meaningful alongside char_valid, so it stays low elsewhere.
        s_if.char_last  = w_last;
        busy            = 1'b1;
        if (s_if.char_ready) w_state_next = w_last ? DONE : COLLECT;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_state_next = COLLECT;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign s_if.char_data = r_char;
  assign char_count     = r_count;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_stego_lsb_extractor.sv
// Self-checking bench: three extractor instances (default, MAX_CHARS=2, MSB_FIRST=0)
// checked every cycle against a bit-queue reference model plus literal expectations.
module tb_stego_lsb_extractor;
  import stego_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_s[3];
  logic       pv[3];
  logic [7:0] pd[3];
  logic       cr[3];
  int         cr_mode[3] = '{1, 1, 1};

  logic       pr[3], cv[3], cl[3], bz[3], dn[3];
  logic [7:0] cd[3];
  logic [7:0] cc[3];
  state_t     dbg[3];

  int checks = 0;
  int errors = 0;

  int mx[3]  = '{130, 2, 130};
  int msb[3] = '{1, 1, 0};
  int m_mode[3], m_nbits[3], m_acc[3], m_char[3], m_count[3];

  stego_lsb_extractor_if if0 ();
  stego_lsb_extractor_if if1 ();
  stego_lsb_extractor_if if2 ();

  assign if0.pix_valid = pv[0];
  assign if0.pix_data = pd[0];
  assign if0.char_ready = cr[0];
  assign if1.pix_valid = pv[1];
  assign if1.pix_data = pd[1];
  assign if1.char_ready = cr[1];
  assign if2.pix_valid = pv[2];
  assign if2.pix_data = pd[2];
  assign if2.char_ready = cr[2];
  assign pr[0] = if0.pix_ready;
  assign cv[0] = if0.char_valid;
  assign cd[0] = if0.char_data;
  assign cl[0] = if0.char_last;
  assign pr[1] = if1.pix_ready;
  assign cv[1] = if1.char_valid;
  assign cd[1] = if1.char_data;
  assign cl[1] = if1.char_last;
  assign pr[2] = if2.pix_ready;
  assign cv[2] = if2.char_valid;
  assign cd[2] = if2.char_data;
  assign cl[2] = if2.char_last;

  stego_lsb_extractor #(.MAX_CHARS(130), .MSB_FIRST(1), .CNT_W(8)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .s_if(if0),
    .busy(bz[0]), .done(dn[0]), .char_count(cc[0]), .o_dbg_state(dbg[0]));
  stego_lsb_extractor #(.MAX_CHARS(2), .MSB_FIRST(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .s_if(if1),
    .busy(bz[1]), .done(dn[1]), .char_count(cc[1]), .o_dbg_state(dbg[1]));
  stego_lsb_extractor #(.MAX_CHARS(130), .MSB_FIRST(0), .CNT_W(8)) u_dut2 (
    .clk(clk), .reset(reset), .start(start_s[2]), .s_if(if2),
    .busy(bz[2]), .done(dn[2]), .char_count(cc[2]), .o_dbg_state(dbg[2]));

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // char_ready generator; runs after the driver so mode changes apply on the next edge
  initial begin
    for (int k = 0; k < 3; k++) cr[k] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        case (cr_mode[k])
          0:       cr[k] = 1'b0;
          1:       cr[k] = 1'b1;
          default: cr[k] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  // Reference model: compare expectations on the falling edge, then advance the model
  // with the inputs the DUT will sample on the coming rising edge.
  initial begin
    int b;
    int lst;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (reset) begin
          m_mode[k] = 0; m_nbits[k] = 0; m_acc[k] = 0; m_char[k] = 0; m_count[k] = 0;
          chk("rst_char_data", k, int'(cd[k]), 0);
          chk("rst_char_last", k, int'(cl[k]), 0);
        end
        chk("pix_ready", k, int'(pr[k]), int'(m_mode[k] == 1));
        chk("char_valid", k, int'(cv[k]), int'(m_mode[k] == 2));
        chk("busy", k, int'(bz[k]), int'(m_mode[k] == 1 || m_mode[k] == 2));
        chk("done", k, int'(dn[k]), int'(m_mode[k] == 3));
        chk("dbg_done", k, int'(dbg[k] == DONE), int'(m_mode[k] == 3));
        chk("char_count", k, int'(cc[k]), m_count[k]);
        if (m_mode[k] == 2) begin
          chk("char_data", k, int'(cd[k]), m_char[k]);
          chk("char_last", k, int'(cl[k]), int'(m_char[k] == 0 || m_count[k] == mx[k] - 1));
        end
        if (!reset) begin
          case (m_mode[k])
            1: if (pv[k]) begin
              b = int'(pd[k][0]);
              if (msb[k] != 0) m_acc[k] = m_acc[k] * 2 + b;
              else m_acc[k] = m_acc[k] + (b << m_nbits[k]);
              m_nbits[k]++;
              if (m_nbits[k] == 8) begin
                m_char[k] = m_acc[k]; m_acc[k] = 0; m_nbits[k] = 0; m_mode[k] = 2;
              end
            end
            2: if (cr[k]) begin
              lst = int'(m_char[k] == 0 || m_count[k] == mx[k] - 1);
              m_count[k]++;
              m_mode[k] = (lst != 0) ? 3 : 1;
            end
            default: if (start_s[k]) begin
              m_mode[k] = 1; m_nbits[k] = 0; m_acc[k] = 0; m_count[k] = 0;
            end
          endcase
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int k);
    start_s[k] = 1'b1;
    cyc();
    start_s[k] = 1'b0;
  endtask

  // gap: 0 continuous, 1 idle cycle before every pixel, 2 random idle cycles
  task automatic send_pixel(input int k, input logic [7:0] p, input int gap);
    bit ok;
    ok = 1'b0;
    if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
      pv[k] = 1'b0;
      cyc();
    end
    pv[k] = 1'b1;
    pd[k] = p;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (pr[k]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    pv[k] = 1'b0;
    if (!ok) chk("pixel_timeout", k, 0, 1);
  endtask

  task automatic send_bits(input int k, input logic [7:0] ch, input int first_msb,
                           input int from, input int to, input int gap, input int rnd);
    logic       bv;
    logic [6:0] up;
    for (int i = from; i <= to; i++) begin
      bv = (first_msb != 0) ? ch[7 - i] : ch[i];
      up = (rnd != 0) ? 7'($urandom_range(0, 127)) : 7'h7F;
      send_pixel(k, {up, bv}, gap);
    end
  endtask

  task automatic send_char(input int k, input logic [7:0] ch, input int first_msb,
                           input int gap, input int rnd);
    send_bits(k, ch, first_msb, 0, 7, gap, rnd);
  endtask

  task automatic wait_char(input int k, input int exp, input int exp_last, input string nm,
                           input int strict);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (cv[k] && cr[k]) begin
        ok = 1'b1;
        chk(nm, k, int'(cd[k]), exp);
        chk({nm, "_last"}, k, int'(cl[k]), exp_last);
        if (strict != 0) chk({nm, "_latency"}, k, i, 0);
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk({nm, "_timeout"}, k, 0, 1);
  endtask

  initial begin
    int n;
    logic [7:0] c;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; pv[k] = 1'b0; pd[k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pix_ready", 0, int'(pr[0]), 0);
    chk("reset_count", 0, int'(cc[0]), 0);
    cyc();
    reset = 1'b0;
    cyc();

    // basic 'H', MSB first
    start_run(0);
    send_char(0, 8'h48, 1, 0, 0);
    wait_char(0, 8'h48, 0, "t1_char", 1);
    @(negedge clk);
    chk("t1_count", 0, int'(cc[0]), 1);
    chk("t1_collect", 0, int'(pr[0]), 1);
    cyc();

    // terminator
    send_char(0, 8'h69, 1, 0, 0);
    wait_char(0, 8'h69, 0, "t2_i", 0);
    send_char(0, 8'h00, 1, 0, 0);
    wait_char(0, 8'h00, 1, "t2_nul", 0);
    @(negedge clk);
    chk("t2_done", 0, int'(dn[0]), 1);
    chk("t2_count", 0, int'(cc[0]), 3);
    chk("t2_pix_ready", 0, int'(pr[0]), 0);
    cyc();

    // gaps and backpressure
    start_run(0);
    cr_mode[0] = 0;
    send_char(0, 8'h48, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      pv[0] = 1'b1;
      pd[0] = 8'hFF;
      @(negedge clk);
      chk("t3_hold_valid", 0, int'(cv[0]), 1);
      chk("t3_hold_data", 0, int'(cd[0]), 8'h48);
      chk("t3_hold_ready", 0, int'(pr[0]), 0);
      cyc();
    end
    pv[0] = 1'b0;
    cr_mode[0] = 1;
    wait_char(0, 8'h48, 0, "t3_char", 0);
    send_char(0, 8'h65, 1, 1, 1);
    wait_char(0, 8'h65, 0, "t3_next", 0);
    send_char(0, 8'h00, 1, 1, 1);
    wait_char(0, 8'h00, 1, "t3_nul", 0);

    // MAX_CHARS limit
    start_run(1);
    send_char(1, 8'h41, 1, 0, 0);
    wait_char(1, 8'h41, 0, "t4_a", 0);
    send_char(1, 8'h42, 1, 0, 0);
    wait_char(1, 8'h42, 1, "t4_b", 0);
    @(negedge clk);
    chk("t4_done", 1, int'(dn[1]), 1);
    chk("t4_count", 1, int'(cc[1]), 2);
    cyc();
    pv[1] = 1'b1;
    pd[1] = 8'hFE;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t4_c_held", 1, int'(pr[1]), 0);
      cyc();
    end
    pv[1] = 1'b0;

    // reset mid-byte
    start_run(0);
    send_bits(0, 8'h48, 1, 0, 4, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_busy", 0, int'(bz[0]), 0);
    chk("t5_rst_ready", 0, int'(pr[0]), 0);
    chk("t5_rst_valid", 0, int'(cv[0]), 0);
    chk("t5_rst_data", 0, int'(cd[0]), 0);
    cyc();
    reset = 1'b0;
    cyc();
    start_run(0);
    send_char(0, 8'h48, 1, 0, 0);
    wait_char(0, 8'h48, 0, "t5_char", 1);

    // LSB-first ordering, start ignored while collecting
    start_run(2);
    send_bits(2, 8'h48, 1, 0, 2, 0, 0);
    start_run(2);
    send_bits(2, 8'h48, 1, 3, 7, 0, 0);
    wait_char(2, 8'h12, 0, "t6_char", 1);

    // randomized messages with random gaps and backpressure
    send_char(0, 8'h00, 1, 0, 1);
    wait_char(0, 8'h00, 1, "t5_nul", 0);
    cr_mode[0] = 2;
    for (int r = 0; r < 3; r++) begin
      start_run(0);
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        c = 8'($urandom_range(1, 255));
        send_char(0, c, 1, 2, 1);
        wait_char(0, int'(c), 0, "rnd_char", 0);
      end
      send_char(0, 8'h00, 1, 2, 1);
      wait_char(0, 8'h00, 1, "rnd_nul", 0);
      @(negedge clk);
      chk("rnd_count", 0, int'(cc[0]), n + 1);
      cyc();
    end
    cr_mode[2] = 2;
    for (int j = 0; j < 4; j++) begin
      c = 8'($urandom_range(1, 255));
      send_char(2, c, 0, 2, 1);
      wait_char(2, int'(c), 0, "rnd_lsb_char", 0);
    end
    cr_mode[1] = 2;
    start_run(1);
    c = 8'($urandom_range(1, 255));
    send_char(1, c, 1, 2, 1);
    wait_char(1, int'(c), 0, "rnd_lim_0", 0);
    c = 8'($urandom_range(1, 255));
    send_char(1, c, 1, 2, 1);
    wait_char(1, int'(c), 1, "rnd_lim_1", 0);
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
